// File: rtl/handshake_rx_ctrl.sv
// ============================================================================
// handshake_rx_ctrl
//
// Receive-side controller for a 4-phase req/ack handshake driven by an
// asynchronous sender. req_in passes through an NSYNC-flop synchronizer. The
// FSM captures data_in and offers the word on a valid/ready port. Once the
// consumer takes the word, the FSM raises ack_out. When the synchronized
// request falls, it drops ack_out again.
//
// Optional feature macro: HS_TIMEOUT_EN
//   When defined, the FSM abandons the ACK state once TIMEOUT_CYCLES cycles
//   pass with the request still high, and it sets the sticky timeout_err.
//   When undefined, there is no counter, timeout_err is tied low, and ACK
//   waits for the request to fall for as long as it takes.
//
// Parameters
//   NSYNC          synchronizer depth on req_in (>= 2)
//   WIDTH          data width
//   TIMEOUT_CYCLES ACK-state limit in clk cycles (HS_TIMEOUT_EN only)
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset        in   synchronous, active-high
//   req_in       in   asynchronous request from sender
//   data_in      in   sender data, stable while the request is pending
//   ack_out      out  acknowledge to sender (registered)
//   out_valid    out  data_out holds an unaccepted word
//   out_ready    in   consumer accepts when out_valid && out_ready
//   data_out     out  captured word (registered)
//   xfer_count   out  completed transfers, wraps at 16 bits
//   timeout_err  out  sticky timeout flag
// ============================================================================
module handshake_rx_ctrl #(
    parameter int NSYNC          = 2,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [15:0]      xfer_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_IDLE     = 2'd1,
        S_VALID    = 2'd2,
        S_ACK      = 2'd3
    } state_t;

    state_t           r_state;
    logic [NSYNC-1:0] r_sync;
    // Each bit marks that the matching r_sync stage holds a post-reset sample
    // of req_in.
    logic [NSYNC-1:0] r_sync_vld;
    logic             r_ack;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [15:0]      r_count;
    logic             w_req_s;
    logic             w_req_seen_low;

    assign w_req_s = r_sync[NSYNC-1];

    // The chain is cleared by reset. If req_s alone were trusted, a request
    // held high across reset would look low for NSYNC cycles and would then
    // be captured. WAIT_LOW therefore only exits on a low that was really
    // sampled after reset.
    assign w_req_seen_low = r_sync_vld[NSYNC-1] && !w_req_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync     <= {r_sync[NSYNC-2:0], req_in};
            r_sync_vld <= {r_sync_vld[NSYNC-2:0], 1'b1};
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TCNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_tcnt;
    logic             r_terr;

    assign timeout_err = r_terr;
`else
    // No timeout hardware in this build. The parameter is still referenced
    // so that it remains part of the module interface.
    assign timeout_err = 1'b0 && (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT_LOW;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
`ifdef HS_TIMEOUT_EN
            r_tcnt  <= '0;
            r_terr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_WAIT_LOW: begin
                    if (w_req_seen_low) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_req_s) begin
                        r_data  <= data_in;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    // r_valid is always set in this state, so out_ready
                    // alone decides acceptance.
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_ack   <= 1'b1;
                        r_count <= r_count + 16'd1;
                        r_state <= S_ACK;
`ifdef HS_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                S_ACK: begin
                    // A request fall on the limit cycle takes priority, so
                    // the transfer completes without an error.
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef HS_TIMEOUT_EN
                    else if (r_tcnt == TCNT_LIMIT) begin
                        r_ack   <= 1'b0;
                        r_terr  <= 1'b1;
                        r_state <= S_WAIT_LOW;
                    end else begin
                        r_tcnt  <= r_tcnt + CNT_W'(1);
                    end
`endif
                end
                default: r_state <= S_WAIT_LOW;
            endcase
        end
    end

    assign ack_out    = r_ack;
    assign out_valid  = r_valid;
    assign data_out   = r_data;
    assign xfer_count = r_count;

endmodule

// File: tb/tb_handshake_rx_ctrl.sv
module tb_handshake_rx_ctrl;

    localparam int NSYNC = 2;
    localparam int WIDTH = 8;
    localparam int TOUT  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [15:0]      xfer_count;
    logic             timeout_err;

    // out_ready is either driven by the directed phases or randomized.
    logic rdy_dir;
    logic rdy_rand;
    logic rand_mode;
    assign out_ready = rand_mode ? rdy_rand : rdy_dir;

    handshake_rx_ctrl #(
        .NSYNC(NSYNC), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .xfer_count(xfer_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: words the sender has offered and not yet seen accepted,
    // plus the number of accepted words since the last reset.
    logic [WIDTH-1:0] exp_q[$];
    int unsigned      model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input int budget, input string name);
        int n = 0;
        while (ack_out !== v && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, 32'(ack_out), 32'(v));
    endtask

    task automatic offer(input logic [WIDTH-1:0] d);
        data_in = d;
        req_in  = 1'b1;
        exp_q.push_back(d);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_cnt = 0;
    endtask

    // Monitor: every accepted word must be the oldest outstanding offer, and
    // the counter must show all earlier accepts.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("accepted_data", 32'(data_out), 32'(exp_q.pop_front()));
                chk("xfer_count_at_accept", 32'(xfer_count), 32'(model_cnt[15:0]));
                model_cnt++;
            end
        end
    end

    // Randomized consumer
    initial begin
        rdy_rand = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset     = 1'b1;
        req_in    = 1'b0;
        data_in   = '0;
        rdy_dir   = 1'b0;
        rand_mode = 1'b0;
        tick(3);

        // Reset state
        chk("rst_ack_out",     32'(ack_out),     32'd0);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_data_out",    32'(data_out),    32'd0);
        chk("rst_xfer_count",  32'(xfer_count),  32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick(5);

        // Basic transfer with latency checks
        rdy_dir = 1'b1;
        offer(8'hA5);
        tick(NSYNC);
        chk("t1_valid_early", 32'(out_valid), 32'd0);
        tick(1);
        chk("t1_valid_rise", 32'(out_valid), 32'd1);
        chk("t1_data_out",   32'(data_out),  32'hA5);
        tick(1);
        chk("t1_ack_rise",   32'(ack_out),   32'd1);
        chk("t1_valid_fall", 32'(out_valid), 32'd0);
        chk("t1_xfer_count", 32'(xfer_count), 32'd1);
        req_in = 1'b0;
        tick(NSYNC);
        chk("t1_ack_hold",   32'(ack_out),   32'd1);
        tick(1);
        chk("t1_ack_fall",   32'(ack_out),   32'd0);

        // Back-pressure: the word is held for 20 cycles
        rdy_dir = 1'b0;
        offer(8'hA5);
        tick(NSYNC + 1);
        chk("t2_valid_rise", 32'(out_valid), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (out_valid !== 1'b1 || data_out !== 8'hA5 || ack_out !== 1'b0) bad++;
        end
        chk("t2_hold_violations", 32'(bad), 32'd0);
        rdy_dir = 1'b1;
        tick(1);
        chk("t2_ack_rise",   32'(ack_out),    32'd1);
        chk("t2_xfer_count", 32'(xfer_count), 32'd2);
        req_in = 1'b0;
        wait_ack(1'b0, 10, "t2_ack_fall");

        // Reset while VALID with the request still high
        rdy_dir = 1'b0;
        offer(8'h77);
        tick(NSYNC + 1);
        chk("t3_valid_before_reset", 32'(out_valid), 32'd1);
        reset = 1'b1;
        model_reset();
        tick(1);
        chk("t3_rst_valid", 32'(out_valid),  32'd0);
        chk("t3_rst_data",  32'(data_out),   32'd0);
        chk("t3_rst_ack",   32'(ack_out),    32'd0);
        chk("t3_rst_count", 32'(xfer_count), 32'd0);
        reset   = 1'b0;
        rdy_dir = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (out_valid !== 1'b0) bad++;
        end
        chk("t3_no_capture_req_held", 32'(bad), 32'd0);
        req_in = 1'b0;
        tick(NSYNC + 2);
        offer(8'h3C);
        wait_ack(1'b1, 20, "t3_ack_rise");
        chk("t3_xfer_count", 32'(xfer_count), 32'd1);
        req_in = 1'b0;
        wait_ack(1'b0, 10, "t3_ack_fall");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (out_valid !== 1'b0) bad++;
        end
        chk("t3_single_presentation", 32'(bad), 32'd0);

        // Randomized transfers with a random consumer
        rand_mode = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick($urandom_range(0, 3));
            offer(8'($urandom));
            wait_ack(1'b1, 300, "rand_ack_rise");
            tick($urandom_range(0, 3));
            req_in = 1'b0;
            wait_ack(1'b0, 20, "rand_ack_fall");
        end
        rand_mode = 1'b0;
        rdy_dir   = 1'b1;
        chk("rand_xfer_count", 32'(xfer_count), 32'(model_cnt[15:0]));

        // Sub-cycle glitches on req_in are never sampled
        tick(2);
        bad = 0;
        for (int g = 0; g < 5; g++) begin
            data_in = 8'($urandom);
            #2 req_in = 1'b1;
            #3 req_in = 1'b0;
            for (int i = 0; i < NSYNC + 3; i++) begin
                tick(1);
                if (out_valid !== 1'b0) bad++;
            end
        end
        chk("glitch_no_capture", 32'(bad), 32'd0);

`ifdef HS_TIMEOUT_EN
        // Request held high after ack: timeout aborts the handshake
        offer(8'h5A);
        wait_ack(1'b1, 20, "to_ack_rise");
        tick(TOUT - 1);
        chk("to_ack_before_limit", 32'(ack_out),     32'd1);
        chk("to_err_before_limit", 32'(timeout_err), 32'd0);
        tick(1);
        chk("to_ack_dropped", 32'(ack_out),     32'd0);
        chk("to_err_set",     32'(timeout_err), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (out_valid !== 1'b0) bad++;
        end
        chk("to_no_capture_req_held", 32'(bad), 32'd0);
        req_in = 1'b0;
        tick(NSYNC + 2);
        offer(8'h96);
        wait_ack(1'b1, 20, "to_next_ack_rise");
        req_in = 1'b0;
        wait_ack(1'b0, 10, "to_next_ack_fall");
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        reset = 1'b1;
        model_reset();
        tick(1);
        chk("to_err_cleared", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick(5);
`else
        // Without the timeout, ACK waits for the request to fall
        offer(8'hC3);
        wait_ack(1'b1, 20, "hold_ack_rise");
        tick(3 * TOUT);
        chk("hold_ack_still_high", 32'(ack_out),     32'd1);
        chk("hold_no_timeout_err", 32'(timeout_err), 32'd0);
        req_in = 1'b0;
        wait_ack(1'b0, 10, "hold_ack_fall");
`endif

        tick(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
